// File: rtl/elm_pkg.sv
// Shared definitions for the ELM address sequencer.
//   - FSM state encoding (IDLE/RUN/DONE) as legacy-compatible localparams
//   - clog2 helper for width defaults
package elm_pkg;

  typedef logic [1:0] state_t;

  localparam state_t StIdle = 2'd0;
  localparam state_t StRun  = 2'd1;
  localparam state_t StDone = 2'd2;

  // Ceiling log2, clamped to at least 1 so it can size a register directly.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 1;
    for (int i = 1; i < 32; i++) begin
      if ((64'(1) << i) < 64'(v)) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/elm_mod_counter.sv
// Modulo-MODULUS up counter with synchronous clear and advance enable.
// Ports:
//   clk   - clock, rising edge
//   clr   - synchronous clear to 0 (wins over en)
//   en    - advance one count; wraps to 0 after MODULUS-1
//   count - current count
//   tc    - terminal count (count == MODULUS-1)
module elm_mod_counter
  import elm_pkg::*;
#(
  parameter int unsigned MODULUS = 256,
  parameter int unsigned WIDTH   = clog2(MODULUS)
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             en,
  output logic [WIDTH-1:0] count,
  output logic             tc
);

  localparam logic [WIDTH-1:0] Last = WIDTH'(MODULUS - 1);

  logic [WIDTH-1:0] count_q, count_d;

  assign tc    = (count_q == Last);
  assign count = count_q;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en) begin
      count_d = tc ? '0 : count_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    count_q <= count_d;
  end

endmodule

// File: rtl/elm_addr_sequencer.sv
// Two-level (row x column) address sequencer for ELM weight/input memories.
// Ports:
//   clk, rst           - clock and synchronous active-high reset
//   start              - begin a scan (taken in IDLE or DONE)
//   en                 - advance one address (RUN only), otherwise stall
//   clr                - synchronous abort, same effect as rst
//   col_addr/row_addr  - current column / row index
//   lin_addr           - row_addr*N_COLS + col_addr, kept as its own counter
//   valid, busy        - high while in RUN
//   row_done           - 1-cycle pulse after the last column of a row is consumed
//   done               - MODE 0: level in DONE; MODE 1: 1-cycle pulse per scan
module elm_addr_sequencer
  import elm_pkg::*;
#(
  parameter int unsigned N_COLS = 256,
  parameter int unsigned N_ROWS = 1,
  parameter int unsigned COL_W  = 8,
  parameter int unsigned ROW_W  = 1,
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned MODE   = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              en,
  input  logic              clr,
  output logic [COL_W-1:0]  col_addr,
  output logic [ROW_W-1:0]  row_addr,
  output logic [ADDR_W-1:0] lin_addr,
  output logic              valid,
  output logic              row_done,
  output logic              done,
  output logic              busy
);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] lin_q, lin_d;
  logic              row_done_q, row_done_d;
  logic              done_q, done_d;
  logic              kill, step, col_tc, row_tc, last_step;

  assign kill      = rst | clr;
  assign step      = (state_q == StRun) & en;
  assign last_step = step & col_tc & row_tc;

  // Both counters wrap to 0 on the final step, so finishing a scan leaves
  // addresses at 0 without any extra clear.
  elm_mod_counter #(
    .MODULUS (N_COLS),
    .WIDTH   (COL_W)
  ) u_col_cnt (
    .clk   (clk),
    .clr   (kill),
    .en    (step),
    .count (col_addr),
    .tc    (col_tc)
  );

  elm_mod_counter #(
    .MODULUS (N_ROWS),
    .WIDTH   (ROW_W)
  ) u_row_cnt (
    .clk   (clk),
    .clr   (kill),
    .en    (step & col_tc),
    .count (row_addr),
    .tc    (row_tc)
  );

  always_comb begin
    state_d = state_q;
    if (kill) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle:  if (start) state_d = StRun;
        StRun:   if (last_step && (MODE == 0)) state_d = StDone;
        StDone:  if (start) state_d = StRun;
        default: state_d = StIdle;
      endcase
    end
  end

  always_comb begin
    lin_d = lin_q;
    if (kill) begin
      lin_d = '0;
    end else if (step) begin
      lin_d = last_step ? '0 : lin_q + ADDR_W'(1);
    end
  end

  assign row_done_d = ~kill & step & col_tc;
  // One-shot holds done for as long as DONE lasts; continuous pulses it.
  assign done_d     = ~kill & ((MODE == 0) ? (state_d == StDone) : last_step);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      lin_q      <= '0;
      row_done_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      lin_q      <= lin_d;
      row_done_q <= row_done_d;
      done_q     <= done_d;
    end
  end

  assign lin_addr = lin_q;
  assign row_done = row_done_q;
  assign done     = done_q;
  assign valid    = (state_q == StRun);
  assign busy     = (state_q == StRun);

endmodule

// File: tb/tb_elm_addr_sequencer.sv
module tb_elm_addr_sequencer;

  typedef struct packed {
    logic       valid;
    logic       busy;
    logic       done;
    logic       row_done;
    logic [1:0] row;
    logic [7:0] col;
    logic [7:0] lin;
  } obs_t;

  typedef struct {
    obs_t o;
    int   id;
  } item_t;

  logic clk = 1'b0;
  logic rst = 1'b1, start = 1'b0, en = 1'b0, clr = 1'b0;
  always #5 clk = ~clk;

  // DUT A: 4x3 one-shot, DUT B: 4x3 continuous, DUT C: 256x1 one-shot
  logic [1:0] col_a, row_a, col_b, row_b;
  logic [3:0] lin_a, lin_b;
  logic [7:0] col_c, lin_c;
  logic [0:0] row_c;
  logic val_a, rd_a, dn_a, bsy_a;
  logic val_b, rd_b, dn_b, bsy_b;
  logic val_c, rd_c, dn_c, bsy_c;

  elm_addr_sequencer #(.N_COLS(4), .N_ROWS(3), .COL_W(2), .ROW_W(2), .ADDR_W(4), .MODE(0)) u_a (
    .clk(clk), .rst(rst), .start(start), .en(en), .clr(clr),
    .col_addr(col_a), .row_addr(row_a), .lin_addr(lin_a),
    .valid(val_a), .row_done(rd_a), .done(dn_a), .busy(bsy_a)
  );

  elm_addr_sequencer #(.N_COLS(4), .N_ROWS(3), .COL_W(2), .ROW_W(2), .ADDR_W(4), .MODE(1)) u_b (
    .clk(clk), .rst(rst), .start(start), .en(en), .clr(clr),
    .col_addr(col_b), .row_addr(row_b), .lin_addr(lin_b),
    .valid(val_b), .row_done(rd_b), .done(dn_b), .busy(bsy_b)
  );

  elm_addr_sequencer #(.N_COLS(256), .N_ROWS(1), .COL_W(8), .ROW_W(1), .ADDR_W(8), .MODE(0)) u_c (
    .clk(clk), .rst(rst), .start(start), .en(en), .clr(clr),
    .col_addr(col_c), .row_addr(row_c), .lin_addr(lin_c),
    .valid(val_c), .row_done(rd_c), .done(dn_c), .busy(bsy_c)
  );

  obs_t act_a, act_b, act_c;
  always_comb begin
    act_a = '{valid: val_a, busy: bsy_a, done: dn_a, row_done: rd_a,
              row: row_a, col: 8'(col_a), lin: 8'(lin_a)};
    act_b = '{valid: val_b, busy: bsy_b, done: dn_b, row_done: rd_b,
              row: row_b, col: 8'(col_b), lin: 8'(lin_b)};
    act_c = '{valid: val_c, busy: bsy_c, done: dn_c, row_done: rd_c,
              row: 2'(row_c), col: col_c, lin: lin_c};
  end

  item_t qa[$], qb[$], qc[$];
  int n_tests = 0;
  int n_fail  = 0;
  int tid     = 0;

  task automatic cmp(input string tag, input obs_t act, input item_t it);
    n_tests++;
    if (act !== it.o) begin
      n_fail++;
      $display("FAIL %s vec %0d: got v=%b b=%b d=%b rd=%b row=%0d col=%0d lin=%0d, expected v=%b b=%b d=%b rd=%b row=%0d col=%0d lin=%0d",
               tag, it.id, act.valid, act.busy, act.done, act.row_done, act.row, act.col, act.lin,
               it.o.valid, it.o.busy, it.o.done, it.o.row_done, it.o.row, it.o.col, it.o.lin);
    end
  endtask

  // Monitors: one expectation per cycle, checked just after the edge.
  always @(posedge clk) begin
    #1;
    if (qa.size() > 0) cmp("dut_a", act_a, qa.pop_front());
    if (qb.size() > 0) cmp("dut_b", act_b, qb.pop_front());
    if (qc.size() > 0) cmp("dut_c", act_c, qc.pop_front());
  end

  function automatic obs_t mk(input logic v, input int col, input int row, input int lin,
                              input logic rd, input logic dn);
    obs_t o;
    o.valid    = v;
    o.busy     = v;
    o.done     = dn;
    o.row_done = rd;
    o.row      = 2'(row);
    o.col      = 8'(col);
    o.lin      = 8'(lin);
    return o;
  endfunction

  task automatic drive(input logic r, input logic s, input logic e, input logic c);
    @(negedge clk);
    rst = r; start = s; en = e; clr = c;
  endtask

  task automatic pa(input obs_t o); qa.push_back('{o: o, id: tid}); tid++; endtask
  task automatic pb(input obs_t o); qb.push_back('{o: o, id: tid}); tid++; endtask
  task automatic pc(input obs_t o); qc.push_back('{o: o, id: tid}); tid++; endtask

  obs_t z;
  int   l, nl;
  logic enp [8];

  initial begin
    z = mk(0, 0, 0, 0, 0, 0);

    // Test 1: reset, en ignored in IDLE, full one-shot scan
    drive(1, 0, 0, 0); pa(z);
    drive(1, 0, 0, 0); pa(z);
    drive(0, 0, 1, 0); pa(z);
    drive(0, 1, 0, 0); pa(mk(1, 0, 0, 0, 0, 0));
    for (int i = 0; i < 12; i++) begin
      drive(0, 0, 1, 0);
      if (i == 11) pa(mk(0, 0, 0, 0, 1, 1));
      else         pa(mk(1, (i + 1) % 4, (i + 1) / 4, i + 1, (i % 4) == 3, 0));
    end
    drive(0, 0, 0, 0); pa(mk(0, 0, 0, 0, 0, 1));
    drive(0, 0, 1, 0); pa(mk(0, 0, 0, 0, 0, 1));  // en ignored in DONE

    // Test 2: restart from DONE, stalls hold addresses
    drive(0, 1, 0, 0); pa(mk(1, 0, 0, 0, 0, 0));
    l = 0;
    enp = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 8; i++) begin
      drive(0, 0, enp[i], 0);
      if (enp[i]) begin
        pa(mk(1, (l + 1) % 4, (l + 1) / 4, l + 1, (l % 4) == 3, 0));
        l++;
      end else begin
        pa(mk(1, l % 4, l / 4, l, 0, 0));
      end
    end

    // Test 3: clr mid-scan at lin 6, then rescan
    drive(0, 0, 1, 0); pa(mk(1, 1, 1, 5, 0, 0));
    drive(0, 0, 1, 0); pa(mk(1, 2, 1, 6, 0, 0));
    drive(0, 0, 1, 1); pa(z);
    drive(0, 0, 0, 0); pa(z);
    // Test 6: start with clr in IDLE stays IDLE
    drive(0, 1, 0, 1); pa(z);
    drive(0, 1, 0, 0); pa(mk(1, 0, 0, 0, 0, 0));
    drive(0, 0, 1, 0); pa(mk(1, 1, 0, 1, 0, 0));
    drive(0, 1, 1, 0); pa(mk(1, 2, 0, 2, 0, 0));  // start ignored in RUN

    // Test 4: continuous mode, 30 steps
    drive(1, 0, 0, 0); pb(z);
    drive(0, 1, 0, 0); pb(mk(1, 0, 0, 0, 0, 0));
    l = 0;
    for (int i = 0; i < 30; i++) begin
      drive(0, 0, 1, 0);
      nl = (l + 1) % 12;
      pb(mk(1, nl % 4, nl / 4, nl, (l % 4) == 3, l == 11));
      l = nl;
    end
    drive(0, 0, 0, 0); pb(mk(1, l % 4, l / 4, l, 0, 0));

    // Test 5: 256x1 one-shot, restart from DONE
    drive(1, 0, 0, 0); pc(z);
    drive(0, 1, 0, 0); pc(mk(1, 0, 0, 0, 0, 0));
    for (int i = 0; i < 256; i++) begin
      drive(0, 0, 1, 0);
      if (i == 255) pc(mk(0, 0, 0, 0, 1, 1));
      else          pc(mk(1, i + 1, 0, i + 1, 0, 0));
    end
    drive(0, 1, 0, 0); pc(mk(1, 0, 0, 0, 0, 0));
    drive(0, 0, 1, 0); pc(mk(1, 1, 0, 1, 0, 0));

    drive(0, 0, 0, 0);
    for (int i = 0; i < 10; i++) begin
      if (qa.size() == 0 && qb.size() == 0 && qc.size() == 0) break;
      @(posedge clk);
    end
    #2;
    if (qa.size() + qb.size() + qc.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain: %0d expectations left unchecked, expected 0",
               qa.size() + qb.size() + qc.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
